rejection_eta_n: RTL

REJECTION_ETA_N -- requirements
Module: rejection_eta_n

---
 rtl/rejection_eta_n.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rejection_eta_n.sv
// Rejection sampler for centered small-eta polynomial coefficients.
// Random nibbles are taken from a bit buffer, filtered per lane, and the
// accepted coefficients are packed in order into BUS_W-wide output words.

// One nibble lane: the accept test and the coefficient value modulo Q.
module rej_lane #(
    parameter int SAMPLE_W = 23
) (
    input  logic [3:0]          nib,
    input  logic                eta4,
    output logic                acc,
    output logic [SAMPLE_W-1:0] coef
);
    localparam logic [SAMPLE_W-1:0] Q = SAMPLE_W'(8380417);

    logic [3:0] r;

    // negative values wrap to Q - |v|
    always_comb begin
        r   = nib % 4'd5;
        acc = eta4 ? (nib < 4'd9) : (nib < 4'd15);
        if (eta4) begin
            if (nib <= 4'd4) coef = SAMPLE_W'(4'd4 - nib);
            else             coef = Q - SAMPLE_W'(nib - 4'd4);
        end else begin
            if (r <= 4'd2)   coef = SAMPLE_W'(4'd2 - r);
            else             coef = Q - SAMPLE_W'(r - 4'd2);
        end
    end
endmodule

module rejection_eta_n #(
    parameter int W        = 64,
    parameter int LANES    = 4,
    parameter int SAMPLE_W = 23,
    parameter int BUS_W    = 4,
    parameter int N_COEF   = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2:0]                sec_lvl,
    input  logic                      valid_i,
    output logic                      ready_i,
    input  logic [W-1:0]              rdi,
    output logic [SAMPLE_W*BUS_W-1:0] samples,
    output logic                      valid_o,
    input  logic                      ready_o,
    output logic                      last_o,
    output logic                      done
);
    localparam int IBW   = W + 4*LANES;
    localparam int FW    = $clog2(IBW + 1);
    localparam int DEPTH = BUS_W + LANES;
    localparam int OCW   = $clog2(DEPTH + 1);
    localparam int CCW   = $clog2(N_COEF + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                          state, state_n;
    logic [IBW-1:0]                  inbuf, ib_rem, ib_n;
    logic [FW-1:0]                   fill, fill_n;
    logic [SAMPLE_W-1:0]             obuf [DEPTH];
    logic [SAMPLE_W-1:0]             ob_n [DEPTH];
    logic [OCW-1:0]                  out_cnt, oc_n;
    logic [CCW-1:0]                  coef_cnt, cc_n;
    logic [LANES-1:0]                acc;
    logic [LANES-1:0][SAMPLE_W-1:0]  coef;
    logic [LANES-1:0]                wr;
    int                              dst [LANES];
    int                              k, n, oc_pop;
    logic                            pop, push, eta4;

    assign eta4    = (sec_lvl == 3'd3);
    assign ready_i = (state == RUN) && (int'(fill) <= 4*LANES);
    assign valid_o = (state != IDLE) && (int'(out_cnt) >= BUS_W);
    // in DRAIN everything left is in obuf, so a single word means the final one
    assign last_o  = (state == DRAIN) && valid_o && (int'(out_cnt) == BUS_W);

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            rej_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
                .nib  (inbuf[4*g +: 4]),
                .eta4 (eta4),
                .acc  (acc[g]),
                .coef (coef[g])
            );
        end
        for (g = 0; g < BUS_W; g++) begin : g_out
            assign samples[g*SAMPLE_W +: SAMPLE_W] = obuf[g];
        end
    endgenerate

    // consume/accept/pack and push/pop bookkeeping for this cycle
    always_comb begin
        pop    = valid_o && ready_o;
        push   = valid_i && ready_i;
        oc_pop = int'(out_cnt) - (pop ? BUS_W : 0);
        k      = 0;
        // examine nibbles only when a full LANES worth of results is sure to fit
        if (state == RUN && oc_pop <= BUS_W)
            k = (int'(fill) / 4 < LANES) ? int'(fill) / 4 : LANES;
        n = 0;
        for (int i = 0; i < LANES; i++) begin
            wr[i]  = 1'b0;
            dst[i] = 0;
            if (i < k && acc[i] && int'(coef_cnt) + n < N_COEF) begin
                wr[i]  = 1'b1;
                dst[i] = oc_pop + n;
                n      = n + 1;
            end
        end
        for (int j = 0; j < DEPTH - BUS_W; j++)
            ob_n[j] = pop ? obuf[j + BUS_W] : obuf[j];
        for (int j = DEPTH - BUS_W; j < DEPTH; j++)
            ob_n[j] = pop ? '0 : obuf[j];
        for (int j = 0; j < DEPTH; j++)
            for (int i = 0; i < LANES; i++)
                if (wr[i] && dst[i] == j) ob_n[j] = coef[i];
        ib_rem = inbuf >> (4*k);
        ib_n   = push ? (ib_rem | (IBW'(rdi) << (int'(fill) - 4*k))) : ib_rem;
        fill_n = FW'(int'(fill) - 4*k + (push ? W : 0));
        oc_n   = OCW'(oc_pop + n);
        cc_n   = CCW'(int'(coef_cnt) + n);
    end

    // next state
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (int'(cc_n) == N_COEF) state_n = DRAIN;
            DRAIN:   if (pop && last_o) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // buffers, counters and the done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inbuf    <= '0;
            fill     <= '0;
            out_cnt  <= '0;
            coef_cnt <= '0;
            done     <= 1'b0;
            for (int j = 0; j < DEPTH; j++) obuf[j] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    inbuf    <= '0;
                    fill     <= '0;
                    out_cnt  <= '0;
                    coef_cnt <= '0;
                    for (int j = 0; j < DEPTH; j++) obuf[j] <= '0;
                end
                RUN: begin
                    inbuf    <= ib_n;
                    fill     <= fill_n;
                    out_cnt  <= oc_n;
                    coef_cnt <= cc_n;
                    obuf     <= ob_n;
                end
                DRAIN: begin
                    inbuf   <= '0;
                    fill    <= '0;
                    out_cnt <= oc_n;
                    obuf    <= ob_n;
                    if (pop && last_o) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
